// File: rtl/bitwise_operations_if.sv
// Operand/result bundle for the registered bitwise logic unit.
// The master drives operands and op; the slave returns the registered result.
interface bitwise_operations_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic [WIDTH-1:0] q;

  modport master (output a, output b, output op, input q);
  modport slave  (input a, input b, input op, output q);
endinterface

// File: rtl/bitwise_operations.sv
// Registered bitwise logic unit: AND/OR/XOR/NOT of two operands, one result per cycle.
// Single output register with asynchronous active-low clear; no path from inputs to q.
module bitwise_operations #(
  parameter int WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitwise_operations_if.slave  bus
);

  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] r_q;

  // Unreachable encodings (X/Z on op) fall back to AND so no latch is inferred.
  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [WIDTH-1:0] a_in,
    input logic [WIDTH-1:0] b_in,
    input logic [1:0]       op_in
  );
    logic [WIDTH-1:0] res;
    case (op_in)
      2'b01:   res = a_in | b_in;
      2'b10:   res = a_in ^ b_in;
      2'b11:   res = ~a_in;
      default: res = a_in & b_in;
    endcase
    return res;
  endfunction

  always_comb begin
    w_r = f_logic_op(bus.a, bus.b, bus.op);
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_r;
    end
  end

  assign bus.q = r_q;

endmodule

// File: tb/tb_bitwise_operations.sv
// Directed and random checks of bitwise_operations against a per-bit truth-table model.
module tb_bitwise_operations;

  localparam int WIDTH = 7;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  bitwise_operations_if #(.WIDTH(WIDTH)) bus ();

  bitwise_operations #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each result bit from arithmetic on the operand bits.
  function automatic logic [WIDTH-1:0] model(
    input logic [WIDTH-1:0] ma,
    input logic [WIDTH-1:0] mb,
    input logic [1:0]       mop
  );
    logic [WIDTH-1:0] res;
    int ai, bi, ri;
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ai = ma[i] ? 1 : 0;
      bi = mb[i] ? 1 : 0;
      case (mop)
        2'd0:    ri = ai * bi;
        2'd1:    ri = ai + bi - ai * bi;
        2'd2:    ri = (ai + bi) % 2;
        default: ri = 1 - ai;
      endcase
      res[i] = (ri != 0);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic [1:0] top);
    bus.a  = ta;
    bus.b  = tb;
    bus.op = top;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] ra, rb, exp_q;
  logic [1:0]       rop;
  logic [WIDTH-1:0] ext_a [4];
  logic [WIDTH-1:0] ext_b [4];
  logic [1:0]       cyc_op [4];
  logic [WIDTH-1:0] cyc_q  [4];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b1;
    drive(7'h7F, 7'h7F, 2'b01);
    #2 rst_n = 1'b0;

    // Held in reset while clock toggles and inputs would give 7F
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", bus.q, '0);
    end
    rst_n = 1'b1;

    // AND: result appears only after the edge
    drive(7'b1010101, 7'b1100110, 2'b00);
    #2;
    check("and_before_edge", bus.q, '0);
    tick();
    check("and", bus.q, 7'b1000100);

    drive(7'b1010101, 7'b1100110, 2'b01);
    tick();
    check("or", bus.q, 7'b1110111);

    drive(7'b1010101, 7'b1100110, 2'b10);
    tick();
    check("xor", bus.q, 7'b0110011);

    drive(7'b1010101, 7'b1111111, 2'b11);
    tick();
    check("not_b_ones", bus.q, 7'b0101010);
    drive(7'b1010101, 7'b0000000, 2'b11);
    tick();
    check("not_b_zero", bus.q, 7'b0101010);

    // Asynchronous reset mid-cycle
    drive(7'h55, 7'h7F, 2'b00);
    tick();
    check("pre_async_55", bus.q, 7'h55);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", bus.q, '0);
    tick();
    check("async_hold", bus.q, '0);
    rst_n = 1'b1;

    // Op cycling on consecutive edges
    cyc_op[0] = 2'b00; cyc_q[0] = 7'h0C;
    cyc_op[1] = 2'b01; cyc_q[1] = 7'h3F;
    cyc_op[2] = 2'b11; cyc_q[2] = 7'h43;
    cyc_op[3] = 2'b10; cyc_q[3] = 7'h33;
    for (int i = 0; i < 4; i++) begin
      drive(7'h3C, 7'h0F, cyc_op[i]);
      tick();
      check("op_cycle", bus.q, cyc_q[i]);
    end

    // Extremes for every op
    ext_a[0] = '0;   ext_b[0] = '0;
    ext_a[1] = ONES; ext_b[1] = ONES;
    ext_a[2] = ONES; ext_b[2] = '0;
    ext_a[3] = '0;   ext_b[3] = ONES;
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 4; k++) begin
        drive(ext_a[k], ext_b[k], 2'(o));
        tick();
        check("extreme", bus.q, model(ext_a[k], ext_b[k], 2'(o)));
      end
    end

    // Random: between-edge input changes must not disturb q
    for (int i = 0; i < 40; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rop = 2'($urandom_range(0, 3));
      drive(ra, rb, rop);
      exp_q = model(ra, rb, rop);
      tick();
      check("random", bus.q, exp_q);
      drive(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)));
      #2;
      check("random_hold", bus.q, exp_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
